// File: rtl/imm_gen_pkg.sv
// Shared LEGv8 decode constants: datapath widths, opcode fields and
// immediate format codes used by the immediate generator stage.
package imm_gen_pkg;

    localparam int WORD      = 64;
    localparam int INSTR_LEN = 32;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_D    = 3'd2,
        FMT_CB   = 3'd3,
        FMT_B    = 3'd4,
        FMT_IW   = 3'd5
    } fmt_e;

    // I-type opcodes occupy instr[31:22]
    localparam logic [9:0]  ADDI  = 10'b1001000100;
    localparam logic [9:0]  ANDI  = 10'b1001001000;
    localparam logic [9:0]  EORI  = 10'b1101001000;
    localparam logic [9:0]  ORRI  = 10'b1011001000;
    localparam logic [9:0]  SUBI  = 10'b1101000100;
    localparam logic [9:0]  CMPI  = 10'b1111000100;
    localparam logic [10:0] LDUR  = 11'b11111000010;
    localparam logic [10:0] STUR  = 11'b11111000000;
    localparam logic [7:0]  CBZ   = 8'b10110100;
    localparam logic [7:0]  BCOND = 8'b01010100;
    localparam logic [5:0]  B     = 6'b000101;
    localparam logic [8:0]  MOVZ  = 9'b110100101;
    localparam logic [8:0]  MOVK  = 9'b111100101;

endpackage

// File: rtl/imm_gen_if.sv
// Valid/ready bundle between the IF/ID register, the immediate
// generator and the register-read stage.
interface imm_gen_if #(
    parameter int WORD      = imm_gen_pkg::WORD,
    parameter int INSTR_LEN = imm_gen_pkg::INSTR_LEN
);
    import imm_gen_pkg::*;

    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [INSTR_LEN-1:0] in_instr;
    logic [WORD-1:0]      in_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [INSTR_LEN-1:0] out_instr;
    logic [WORD-1:0]      out_imm;
    logic [WORD-1:0]      out_target;
    logic [WORD-1:0]      out_mask;
    fmt_e                 out_fmt;
    logic                 out_fault;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_imm,
        input  out_target, out_mask, out_fmt, out_fault
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_imm,
        output out_target, out_mask, out_fmt, out_fault
    );

endinterface

// File: rtl/imm_gen_stage_imm_decode.sv
// Combinational LEGv8 immediate extraction, extension, branch
// pre-shift and target computation.
module imm_decode #(
    parameter int WORD         = imm_gen_pkg::WORD,
    parameter int INSTR_LEN    = imm_gen_pkg::INSTR_LEN,
    parameter int SHIFT_BRANCH = 1
) (
    input  logic [INSTR_LEN-1:0] instr,
    input  logic [WORD-1:0]      pc,
    output logic [WORD-1:0]      imm,
    output logic [WORD-1:0]      target,
    output logic [WORD-1:0]      mask,
    output imm_gen_pkg::fmt_e    fmt,
    output logic                 fault
);
    import imm_gen_pkg::*;

    logic [10:0]     op;
    logic            is_i, is_d, is_cb, is_b, is_iw;
    logic [5:0]      sh;
    logic            iw_bad;
    logic [WORD-1:0] br_raw;
    logic [WORD-1:0] br_imm;
    logic [WORD-1:0] iw_val;
    logic [WORD-1:0] iw_msk;

    assign op    = instr[31:21];
    assign is_i  = op[10:1] inside {ADDI, ANDI, EORI, ORRI, SUBI, CMPI};
    assign is_d  = op inside {LDUR, STUR};
    assign is_cb = op[10:3] inside {CBZ, BCOND};
    assign is_b  = op[10:5] == B;
    assign is_iw = op[10:2] inside {MOVZ, MOVK};

    assign sh     = {instr[22:21], 4'b0000};
    assign iw_bad = (WORD < 64) && instr[22];
    assign iw_val = {{(WORD-16){1'b0}}, instr[20:5]} << sh;
    assign iw_msk = {{(WORD-16){1'b0}}, 16'hFFFF} << sh;

    always_comb begin
        br_raw = '0;
        unique case (1'b1)
            is_cb:   br_raw = {{(WORD-19){instr[23]}}, instr[23:5]};
            is_b:    br_raw = {{(WORD-26){instr[25]}}, instr[25:0]};
            default: br_raw = '0;
        endcase
    end

    // Bits shifted past the MSB are intentionally dropped
    assign br_imm = (SHIFT_BRANCH != 0) ? (br_raw << 2) : br_raw;

    always_comb begin
        imm    = '0;
        target = '0;
        mask   = '0;
        fmt    = FMT_NONE;
        fault  = 1'b0;
        unique case (1'b1)
            is_i: begin
                imm = {{(WORD-12){instr[21]}}, instr[21:10]};
                fmt = FMT_I;
            end
            is_d: begin
                imm = {{(WORD-9){instr[20]}}, instr[20:12]};
                fmt = FMT_D;
            end
            is_cb: begin
                imm    = br_imm;
                target = pc + br_imm;
                fmt    = FMT_CB;
            end
            is_b: begin
                imm    = br_imm;
                target = pc + br_imm;
                fmt    = FMT_B;
            end
            is_iw: begin
                fmt   = FMT_IW;
                fault = iw_bad;
                imm   = iw_bad ? '0 : iw_val;
                mask  = iw_bad ? '0 : iw_msk;
            end
            default: imm = WORD'(instr);
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator between IF/ID and register read,
// with a valid/ready handshake backed by a one-entry skid register.
module imm_gen_stage #(
    parameter int WORD         = imm_gen_pkg::WORD,
    parameter int INSTR_LEN    = imm_gen_pkg::INSTR_LEN,
    parameter int SHIFT_BRANCH = 1
) (
    input logic       clk,
    input logic       rst_n,
    imm_gen_if.slave  bus
);
    import imm_gen_pkg::*;

    typedef struct packed {
        logic [INSTR_LEN-1:0] instr;
        logic [WORD-1:0]      imm;
        logic [WORD-1:0]      target;
        logic [WORD-1:0]      mask;
        fmt_e                 fmt;
        logic                 fault;
    } entry_t;

    logic [WORD-1:0] d_imm, d_target, d_mask;
    fmt_e            d_fmt;
    logic            d_fault;
    entry_t          dec, o_q, s_q;
    logic            o_v, s_v;
    logic            rdy, acc, room;

    imm_decode #(
        .WORD         (WORD),
        .INSTR_LEN    (INSTR_LEN),
        .SHIFT_BRANCH (SHIFT_BRANCH)
    ) u_dec (
        .instr  (bus.in_instr),
        .pc     (bus.in_pc),
        .imm    (d_imm),
        .target (d_target),
        .mask   (d_mask),
        .fmt    (d_fmt),
        .fault  (d_fault)
    );

    always_comb begin
        dec        = '0;
        dec.instr  = bus.in_instr;
        dec.imm    = d_imm;
        dec.target = d_target;
        dec.mask   = d_mask;
        dec.fmt    = d_fmt;
        dec.fault  = d_fault;
    end

    // s_v is a flop, so in_ready is a registered signal
    assign rdy  = !s_v;
    assign acc  = bus.in_valid && rdy;
    assign room = !o_v || bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_v <= 1'b0;
            s_v <= 1'b0;
            o_q <= '0;
            s_q <= '0;
        end else if (bus.flush) begin
            o_v <= 1'b0;
            s_v <= 1'b0;
        end else if (room) begin
            if (s_v) begin
                o_q <= s_q;
                o_v <= 1'b1;
                s_v <= 1'b0;
            end else if (acc) begin
                o_q <= dec;
                o_v <= 1'b1;
            end else begin
                o_v <= 1'b0;
            end
        end else if (acc) begin
            s_q <= dec;
            s_v <= 1'b1;
        end
    end

    assign bus.in_ready   = rdy;
    assign bus.out_valid  = o_v;
    assign bus.out_instr  = o_q.instr;
    assign bus.out_imm    = o_q.imm;
    assign bus.out_target = o_q.target;
    assign bus.out_mask   = o_q.mask;
    assign bus.out_fmt    = o_q.fmt;
    assign bus.out_fault  = o_q.fault;

endmodule
